color_sequencer: RTL and testbench



---
 rtl/color_seq_pkg.sv | 37 +++
 rtl/color_palette_rf.sv | 35 +++
 rtl/color_sequencer.sv | 135 +++++++++++++
 tb/tb_color_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/color_seq_pkg.sv
// Shared constants for the color sequencer: register map, FSM encoding,
// and the reset contents of the palette and control registers.
package color_seq_pkg;

    // Register addresses on the write-only peripheral bus.
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_MANUAL = 4'h1;
    localparam logic [3:0] ADDR_DIV    = 4'h2;
    localparam logic [3:0] ADDR_LEN    = 4'h3;

    // Reset values of the control registers.
    localparam logic [5:0] RESET_MANUAL = 6'h3F;
    localparam logic [5:0] RESET_COLOR  = 6'h3F;
    localparam int         RESET_DIV    = 59;
    localparam logic [2:0] RESET_LEN    = 3'd7;

    typedef enum logic [1:0] {
        MANUAL   = 2'b00,
        AUTO_ARM = 2'b01,
        AUTO_RUN = 2'b10
    } seq_state_t;

    // Reset palette: white, red, green, blue, yellow, cyan, magenta, grey.
    function automatic logic [5:0] reset_pal(input int i);
        case (i)
            0:       return 6'h3F;
            1:       return 6'h30;
            2:       return 6'h0C;
            3:       return 6'h03;
            4:       return 6'h3C;
            5:       return 6'h0F;
            6:       return 6'h33;
            default: return 6'h15;
        endcase
    endfunction

endpackage

// File: rtl/color_palette_rf.sv
// Palette register file: synchronous write, asynchronous read on two ports
// (entry 0 for arming, one addressed port for stepping), reset to defaults.
module color_palette_rf
    import color_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [5:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [5:0]    rdata,
    output logic [5:0]    rdata0
);

    logic [5:0] mem [DEPTH];

    // Storage: reset loads the default palette, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= reset_pal(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata  = mem[raddr];
    assign rdata0 = mem[0];

endmodule

// File: rtl/color_sequencer.sv
// Frame-synchronous color controller. Holds a manual color and a palette,
// and in auto mode steps through the palette every DIV+1 frames. color_reg
// only ever changes on a vsync rising edge so a frame is never torn.
//
// Write bus: wr_en is a single-cycle strobe with no backpressure; every
// write (any address) is accepted on the edge where wr_en is high and is
// acknowledged by wr_ack high for exactly the following cycle.
module color_sequencer
    import color_seq_pkg::*;
#(
    parameter int PAL_DEPTH = 8,
    parameter int DIV_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic [5:0] color_reg,
    output logic [1:0] state,
    output logic       frame_tick
);

    localparam int AW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;

    logic             vsync_q;
    logic             vs_rise;
    logic [5:0]       manual_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       len_q;
    logic [2:0]       idx_q;
    logic [2:0]       nxt_idx;
    logic [DIV_W-1:0] cnt_q;
    seq_state_t       state_q;
    logic [5:0]       color_q;
    logic             wr_ack_q;
    logic             tick_q;
    logic             wr_ctrl;
    logic             pal_we;
    logic [5:0]       pal_nxt;
    logic [5:0]       pal_0;

    assign vs_rise = vsync & ~vsync_q;
    assign wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);
    assign pal_we  = wr_en && wr_addr[3] && (int'(wr_addr[2:0]) < PAL_DEPTH);
    assign nxt_idx = (idx_q >= len_q) ? 3'd0 : idx_q + 3'd1;

    color_palette_rf #(
        .DEPTH (PAL_DEPTH),
        .AW    (AW)
    ) u_pal (
        .clk    (clk),
        .rst    (rst),
        .we     (pal_we),
        .waddr  (wr_addr[AW-1:0]),
        .wdata  (wr_data[5:0]),
        .raddr  (nxt_idx[AW-1:0]),
        .rdata  (pal_nxt),
        .rdata0 (pal_0)
    );

    // Edge detect, acknowledge and the write-only control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            tick_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            manual_q <= RESET_MANUAL;
            div_q    <= DIV_W'(RESET_DIV);
            len_q    <= RESET_LEN;
        end else begin
            vsync_q  <= vsync;
            tick_q   <= vs_rise;
            wr_ack_q <= wr_en;
            if (wr_en) begin
                case (wr_addr)
                    ADDR_MANUAL: manual_q <= wr_data[5:0];
                    ADDR_DIV:    div_q    <= wr_data[DIV_W-1:0];
                    ADDR_LEN:    len_q    <= wr_data[2:0];
                    default:     ;
                endcase
            end
        end
    end

    // Sequencer FSM. All decisions use pre-edge values, so a write landing
    // on the same edge as a frame rise only influences the next rise.
    // A CTRL write overrides the frame-driven state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            color_q <= RESET_COLOR;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MANUAL: begin
                    if (vs_rise) color_q <= manual_q;
                end
                AUTO_ARM: begin
                    if (vs_rise) begin
                        color_q <= pal_0;
                        idx_q   <= 3'd0;
                        cnt_q   <= '0;
                        state_q <= AUTO_RUN;
                    end
                end
                AUTO_RUN: begin
                    if (vs_rise) begin
                        // A DIV lowered below cnt lets cnt wrap around rather than step early.
                        if (cnt_q == div_q) begin
                            idx_q   <= nxt_idx;
                            color_q <= pal_nxt;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= MANUAL;
            endcase
            if (wr_ctrl) begin
                state_q <= wr_data[0] ? AUTO_ARM : MANUAL;
            end
        end
    end

    assign wr_ack     = wr_ack_q;
    assign color_reg  = color_q;
    assign state      = state_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: write bus, manual mode, auto stepping,
// LEN wrap, same-edge write, and reset behaviour.
module tb_color_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [5:0] color_reg;
    logic [1:0] state;
    logic       frame_tick;

    int tests_run = 0;
    int tests_failed = 0;

    color_sequencer #(
        .PAL_DEPTH (8),
        .DIV_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .color_reg  (color_reg),
        .state      (state),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        chk("wr_ack_high", {7'd0, wr_ack}, 8'd1);
        wr_en = 1'b0;
        tick();
        chk("wr_ack_low", {7'd0, wr_ack}, 8'd0);
    endtask

    // One vsync pulse held for two cycles; checks outputs one edge after the rise.
    task automatic pulse(input string tag, input logic [5:0] exp_color, input logic [1:0] exp_state);
        vsync = 1'b1;
        tick();
        chk({tag, "_tick"}, {7'd0, frame_tick}, 8'd1);
        chk({tag, "_color"}, {2'd0, color_reg}, {2'd0, exp_color});
        chk({tag, "_state"}, {6'd0, state}, {6'd0, exp_state});
        tick();
        chk({tag, "_tick_once"}, {7'd0, frame_tick}, 8'd0);
        vsync = 1'b0;
        tick();
        tick();
    endtask

    logic [5:0] seq_exp [7];

    initial begin
        rst = 1'b1; vsync = 1'b0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_color", {2'd0, color_reg}, 8'h3F);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_ack", {7'd0, wr_ack}, 8'd0);
        chk("rst_tick", {7'd0, frame_tick}, 8'd0);

        // Three frames in MANUAL with reset manual color.
        pulse("man0", 6'h3F, 2'b00);
        pulse("man1", 6'h3F, 2'b00);
        pulse("man2", 6'h3F, 2'b00);

        // New manual color only shows on the next rise.
        wr(4'h1, 8'h05);
        chk("man_before_rise", {2'd0, color_reg}, 8'h3F);
        pulse("man05", 6'h05, 2'b00);

        // DIV=1, LEN=2, auto: 3F 3F 30 30 0C 0C 3F.
        wr(4'h2, 8'd1);
        wr(4'h3, 8'd2);
        wr(4'h0, 8'd1);
        chk("arm_state", {6'd0, state}, 8'd1);
        seq_exp = '{6'h3F, 6'h3F, 6'h30, 6'h30, 6'h0C, 6'h0C, 6'h3F};
        for (int i = 0; i < 7; i++) begin
            pulse($sformatf("auto%0d", i), seq_exp[i], 2'b10);
        end

        // Re-arm with DIV=0, LEN=7; walk to idx 5, then shrink LEN to 2.
        wr(4'h2, 8'd0);
        wr(4'h3, 8'd7);
        wr(4'h0, 8'd1);
        chk("rearm_state", {6'd0, state}, 8'd1);
        pulse("walk_arm", 6'h3F, 2'b10);
        pulse("walk1", 6'h30, 2'b10);
        pulse("walk2", 6'h0C, 2'b10);
        pulse("walk3", 6'h03, 2'b10);
        pulse("walk4", 6'h3C, 2'b10);
        pulse("walk5", 6'h0F, 2'b10);
        wr(4'h3, 8'd2);
        pulse("len_wrap", 6'h3F, 2'b10);

        // Back to MANUAL: color holds until the next rise.
        wr(4'h0, 8'd0);
        chk("man_state", {6'd0, state}, 8'd0);
        chk("man_hold", {2'd0, color_reg}, 8'h3F);
        pulse("man_back", 6'h05, 2'b00);

        // Write MANUAL on the same edge as the rise.
        vsync = 1'b1; wr_en = 1'b1; wr_addr = 4'h1; wr_data = 8'h2A;
        tick();
        chk("same_edge_color", {2'd0, color_reg}, 8'h05);
        chk("same_edge_tick", {7'd0, frame_tick}, 8'd1);
        chk("same_edge_ack", {7'd0, wr_ack}, 8'd1);
        wr_en = 1'b0;
        tick();
        vsync = 1'b0;
        tick(); tick();
        pulse("same_edge_next", 6'h2A, 2'b00);

        // Reset mid-count in AUTO_RUN, with a write and rise on the same edge.
        wr(4'h8, 8'h11);
        wr(4'h2, 8'd5);
        wr(4'h0, 8'd1);
        pulse("pre_rst_arm", 6'h11, 2'b10);
        pulse("pre_rst_cnt", 6'h11, 2'b10);
        rst = 1'b1; vsync = 1'b1; wr_en = 1'b1; wr_addr = 4'h1; wr_data = 8'h07;
        tick();
        chk("mid_rst_color", {2'd0, color_reg}, 8'h3F);
        chk("mid_rst_state", {6'd0, state}, 8'd0);
        chk("mid_rst_ack", {7'd0, wr_ack}, 8'd0);
        chk("mid_rst_tick", {7'd0, frame_tick}, 8'd0);
        rst = 1'b0; wr_en = 1'b0; vsync = 1'b0;
        tick(); tick();
        pulse("post_rst", 6'h3F, 2'b00);

        // Palette restored by reset: arming shows the default entry 0.
        wr(4'h0, 8'd1);
        pulse("post_rst_arm", 6'h3F, 2'b10);

        // vsync high across reset release counts as a rise right away.
        rst = 1'b1; vsync = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_release_rise", {7'd0, frame_tick}, 8'd1);
        chk("rst_release_color", {2'd0, color_reg}, 8'h3F);
        vsync = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
